// File: rtl/idex_pipe_reg.sv
// ID/EX pipeline register: DEPTH slots in series with stall, flush, per-entry valid,
// bubble gating of invalid inputs and a saturating bubble counter.
module idex_pipe_reg #(
  parameter int DATA_W = 32,
  parameter int REG_W  = 5,
  parameter int WB_W   = 2,
  parameter int M_W    = 2,
  parameter int EX_W   = 4,
  parameter int DEPTH  = 1,
  parameter int CNT_W  = 8
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              stall_i,
  input  logic              flush_i,
  input  logic              valid_i,
  input  logic [WB_W-1:0]   WB_i,
  input  logic [M_W-1:0]    M_i,
  input  logic [EX_W-1:0]   EX_i,
  input  logic [DATA_W-1:0] data1_i,
  input  logic [DATA_W-1:0] data2_i,
  input  logic [DATA_W-1:0] signextend_i,
  input  logic [REG_W-1:0]  rs_i,
  input  logic [REG_W-1:0]  rt_i,
  input  logic [REG_W-1:0]  rd_i,
  output logic              valid_o,
  output logic [WB_W-1:0]   WB_o,
  output logic [M_W-1:0]    M_o,
  output logic [EX_W-1:0]   EX_o,
  output logic [DATA_W-1:0] data1_o,
  output logic [DATA_W-1:0] data2_o,
  output logic [DATA_W-1:0] signextend_o,
  output logic [REG_W-1:0]  rs_o,
  output logic [REG_W-1:0]  rt_o,
  output logic [REG_W-1:0]  rd_o,
  output logic [CNT_W-1:0]  bubble_cnt_o
);

  typedef struct packed {
    logic              valid;
    logic [WB_W-1:0]   wb;
    logic [M_W-1:0]    m;
    logic [EX_W-1:0]   ex;
    logic [DATA_W-1:0] data1;
    logic [DATA_W-1:0] data2;
    logic [DATA_W-1:0] sext;
    logic [REG_W-1:0]  rs;
    logic [REG_W-1:0]  rt;
    logic [REG_W-1:0]  rd;
  } entry_t;

  entry_t           r_slot [DEPTH];
  logic [CNT_W-1:0] r_bubble_cnt;
  entry_t           w_in;
  logic             w_cnt_sat;

  // Invalid inputs collapse to an all-zero bubble so no stray writes reach WB/MEM.
  always_comb begin
    w_in = '0;
    if (valid_i) begin
      w_in.valid = 1'b1;
      w_in.wb    = WB_i;
      w_in.m     = M_i;
      w_in.ex    = EX_i;
      w_in.data1 = data1_i;
      w_in.data2 = data2_i;
      w_in.sext  = signextend_i;
      w_in.rs    = rs_i;
      w_in.rt    = rt_i;
      w_in.rd    = rd_i;
    end else begin
      w_in = '0;
    end
  end

  assign w_cnt_sat = (r_bubble_cnt == {CNT_W{1'b1}});

  // Slot chain and bubble counter; priority is reset > flush > stall > advance.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int k = 0; k < DEPTH; k++) r_slot[k] <= '0;
      r_bubble_cnt <= '0;
    end else if (flush_i) begin
      for (int k = 0; k < DEPTH; k++) r_slot[k] <= '0;
      if (!w_cnt_sat) r_bubble_cnt <= r_bubble_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
    end else if (!stall_i) begin
      r_slot[0] <= w_in;
      for (int k = 1; k < DEPTH; k++) r_slot[k] <= r_slot[k-1];
      if (!valid_i && !w_cnt_sat) r_bubble_cnt <= r_bubble_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  assign valid_o      = r_slot[DEPTH-1].valid;
  assign WB_o         = r_slot[DEPTH-1].wb;
  assign M_o          = r_slot[DEPTH-1].m;
  assign EX_o         = r_slot[DEPTH-1].ex;
  assign data1_o      = r_slot[DEPTH-1].data1;
  assign data2_o      = r_slot[DEPTH-1].data2;
  assign signextend_o = r_slot[DEPTH-1].sext;
  assign rs_o         = r_slot[DEPTH-1].rs;
  assign rt_o         = r_slot[DEPTH-1].rt;
  assign rd_o         = r_slot[DEPTH-1].rd;
  assign bubble_cnt_o = r_bubble_cnt;

endmodule
